// File: rtl/fp_mul_pkg.sv
// Shared definitions for the single-precision multiplier back end.
// Holds the binary32 exponent constants, the canonical quiet NaN and the
// stage-1 (post-normalize) pipeline register layout.
// The internal exponent is carried at S1_EXP_W bits signed. This is wide
// enough that in_exp + 2 never wraps for any EXP_W up to S1_EXP_W - 2.
package fp_mul_pkg;

  localparam int S1_EXP_W = 16;
  localparam int EXP_BIAS = 127;

  localparam logic signed [S1_EXP_W-1:0] EXP_MAX  = 16'sd255;
  localparam logic signed [S1_EXP_W-1:0] EXP_ZERO = 16'sd0;
  localparam logic signed [S1_EXP_W-1:0] EXP_ONE  = 16'sd1;
  localparam logic [31:0]                QNAN     = 32'h7FC00000;

  typedef struct packed {
    logic                       valid;
    logic                       sign;
    logic signed [S1_EXP_W-1:0] exp;
    logic [23:0]                mant24;
    logic                       guard;
    logic                       sticky;
    logic                       nan;
    logic                       inf;
    logic                       zero;
  } s1_t;

endpackage

// File: rtl/fp_mul_normalize_round_round.sv
// fp_round_rne: combinational round-to-nearest-even on a 24-bit mantissa
// that carries its hidden bit.
// Ports:
//   mant24/guard/sticky : normalized mantissa plus its guard and sticky bits
//   exp                 : signed exponent belonging to mant24
//   mant                : rounded 24-bit mantissa (hidden bit at [23])
//   exp_out             : exponent after a possible rounding carry
//   inexact             : guard | sticky (bits were discarded)
// The adder's rounding stage can reuse this block unchanged.
module fp_round_rne #(
  parameter int EW = 16
) (
  input  logic [23:0]          mant24,
  input  logic                 guard,
  input  logic                 sticky,
  input  logic signed [EW-1:0] exp,
  output logic [23:0]          mant,
  output logic signed [EW-1:0] exp_out,
  output logic                 inexact
);

  logic        round_up_s;
  logic [24:0] sum_s;

  // Ties go to the even neighbour: a bare guard bit rounds up only when the LSB is 1.
  assign round_up_s = guard & (sticky | mant24[0]);
  assign sum_s      = {1'b0, mant24} + {24'h000000, round_up_s};

  // A carry out of the 25-bit sum means 1.111..1 rounded to 10.000..0, so renormalize.
  always_comb begin
    mant    = sum_s[23:0];
    exp_out = exp;
    inexact = guard | sticky;
    if (sum_s[24]) begin
      mant    = 24'h800000;
      exp_out = exp + EW'(1'b1);
    end else begin
      mant    = sum_s[23:0];
      exp_out = exp;
    end
  end

endmodule

// File: rtl/fp_mul_normalize_round.sv
// fp_mul_normalize_round: two-stage normalize / round / pack stage of the
// binary32 multiplier. It consumes the 48-bit raw mantissa product and
// produces an IEEE-754 result using round-to-nearest-even and flush-to-zero.
// Ports:
//   clk, rst                    : clock, synchronous active-high reset
//   in_valid / in_ready         : input handshake (in_ready = pipeline enable)
//   in_sign, in_exp, in_product : sign, signed pre-normalize exponent, raw product
//   in_nan, in_inf, in_zero     : special-case flags from the unpack stage
//   out_valid / out_ready       : output handshake
//   out_result                  : packed binary32
//   out_overflow, out_underflow, out_inexact : exception flags
// The whole pipe advances on one global enable. While stalled, every output holds.
module fp_mul_normalize_round
  import fp_mul_pkg::*;
#(
  parameter int EXP_W = 10
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic                    in_sign,
  input  logic signed [EXP_W-1:0] in_exp,
  input  logic [47:0]             in_product,
  input  logic                    in_nan,
  input  logic                    in_inf,
  input  logic                    in_zero,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [31:0]             out_result,
  output logic                    out_overflow,
  output logic                    out_underflow,
  output logic                    out_inexact
);

  logic                       en_s;
  logic signed [S1_EXP_W-1:0] in_exp_ext_s;
  s1_t                        s1_next_s;
  s1_t                        s1_r;
  logic [23:0]                rnd_mant_s;
  logic signed [S1_EXP_W-1:0] rnd_exp_s;
  logic                       rnd_inexact_s;
  logic [31:0]                res_s;
  logic                       ovf_s;
  logic                       unf_s;
  logic                       inex_s;

  assign en_s         = !out_valid | out_ready;
  assign in_ready     = en_s;
  assign in_exp_ext_s = S1_EXP_W'(in_exp);  // signed cast sign-extends

  // Stage 1: place the leading one at mant24[23] and split off guard/sticky.
  always_comb begin
    s1_next_s       = '0;
    s1_next_s.valid = in_valid;
    s1_next_s.sign  = in_sign;
    s1_next_s.nan   = in_nan;
    s1_next_s.inf   = in_inf;
    s1_next_s.zero  = in_zero;
    if (in_product[47]) begin
      s1_next_s.mant24 = in_product[47:24];
      s1_next_s.guard  = in_product[23];
      s1_next_s.sticky = |in_product[22:0];
      s1_next_s.exp    = in_exp_ext_s + EXP_ONE;
    end else begin
      s1_next_s.mant24 = in_product[46:23];
      s1_next_s.guard  = in_product[22];
      s1_next_s.sticky = |in_product[21:0];
      s1_next_s.exp    = in_exp_ext_s;
    end
  end

  // Stage-1 register, advancing only on the global enable.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_r <= '0;
    end else if (en_s) begin
      s1_r <= s1_next_s;
    end
  end

  fp_round_rne #(
    .EW (S1_EXP_W)
  ) u_round (
    .mant24  (s1_r.mant24),
    .guard   (s1_r.guard),
    .sticky  (s1_r.sticky),
    .exp     (s1_r.exp),
    .mant    (rnd_mant_s),
    .exp_out (rnd_exp_s),
    .inexact (rnd_inexact_s)
  );

  // Stage 2: resolve specials, range-check the rounded exponent, then pack.
  // A non-special beat with no leading one can only be a zero product, so it packs as zero.
  always_comb begin
    res_s  = 32'h00000000;
    ovf_s  = 1'b0;
    unf_s  = 1'b0;
    inex_s = 1'b0;
    if (s1_r.nan) begin
      res_s = QNAN;
    end else if (s1_r.inf) begin
      res_s = {s1_r.sign, 8'hFF, 23'h000000};
    end else if (s1_r.zero || !rnd_mant_s[23]) begin
      res_s = {s1_r.sign, 31'h00000000};
    end else if (rnd_exp_s >= EXP_MAX) begin
      res_s  = {s1_r.sign, 8'hFF, 23'h000000};
      ovf_s  = 1'b1;
      inex_s = 1'b1;
    end else if (rnd_exp_s <= EXP_ZERO) begin
      res_s  = {s1_r.sign, 31'h00000000};
      unf_s  = 1'b1;
      inex_s = 1'b1;
    end else begin
      res_s  = {s1_r.sign, rnd_exp_s[7:0], rnd_mant_s[22:0]};
      inex_s = rnd_inexact_s;
    end
  end

  // Output register. A bubble leaves the last valid result and flags in place.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid     <= 1'b0;
      out_result    <= 32'h00000000;
      out_overflow  <= 1'b0;
      out_underflow <= 1'b0;
      out_inexact   <= 1'b0;
    end else if (en_s) begin
      out_valid <= s1_r.valid;
      if (s1_r.valid) begin
        out_result    <= res_s;
        out_overflow  <= ovf_s;
        out_underflow <= unf_s;
        out_inexact   <= inex_s;
      end
    end
  end

endmodule

// File: tb/tb_fp_mul_normalize_round.sv
module tb_fp_mul_normalize_round;
  import fp_mul_pkg::*;

  localparam int EXP_W = 10;

  logic                    clk = 1'b0;
  logic                    rst;
  logic                    in_valid;
  logic                    in_ready;
  logic                    in_sign;
  logic signed [EXP_W-1:0] in_exp;
  logic [47:0]             in_product;
  logic                    in_nan;
  logic                    in_inf;
  logic                    in_zero;
  logic                    out_valid;
  logic                    out_ready;
  logic [31:0]             out_result;
  logic                    out_overflow;
  logic                    out_underflow;
  logic                    out_inexact;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    string       name;
    logic        sign;
    int          exp;
    logic [47:0] product;
    logic        nan;
    logic        inf;
    logic        zero;
    logic [31:0] res;
    logic [2:0]  flags;  // {overflow, underflow, inexact}
  } vec_t;

  vec_t vecs[$];

  fp_mul_normalize_round #(.EXP_W(EXP_W)) dut (
    .clk           (clk),
    .rst           (rst),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_sign       (in_sign),
    .in_exp        (in_exp),
    .in_product    (in_product),
    .in_nan        (in_nan),
    .in_inf        (in_inf),
    .in_zero       (in_zero),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_result    (out_result),
    .out_overflow  (out_overflow),
    .out_underflow (out_underflow),
    .out_inexact   (out_inexact)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input string name, input logic sign, input int exp,
                              input logic [47:0] product, input logic nan, input logic inf,
                              input logic zero, input logic [31:0] res, input logic [2:0] flags);
    vec_t v;
    v.name = name; v.sign = sign; v.exp = exp; v.product = product;
    v.nan = nan; v.inf = inf; v.zero = zero; v.res = res; v.flags = flags;
    return v;
  endfunction

  task automatic drive(input logic sign, input int exp, input logic [47:0] product,
                       input logic nan, input logic inf, input logic zero);
    in_sign    = sign;
    in_exp     = EXP_W'(exp);
    in_product = product;
    in_nan     = nan;
    in_inf     = inf;
    in_zero    = zero;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [31:0] bp_exp [4];
  logic [31:0] prev_res;
  bit          prev_stall;
  bit          saw_stall;
  int          sent;
  int          rcvd;
  int          extra;

  initial begin
    vecs.push_back(mk("norm_1p5sq",   1'b0, EXP_BIAS,       48'h900000000000, 1'b0, 1'b0, 1'b0, 32'h40100000, 3'b000));
    vecs.push_back(mk("tie_even",     1'b0, EXP_BIAS,       48'h400000400000, 1'b0, 1'b0, 1'b0, 32'h3F800000, 3'b001));
    vecs.push_back(mk("tie_odd",      1'b0, EXP_BIAS,       48'h400000C00000, 1'b0, 1'b0, 1'b0, 32'h3F800002, 3'b001));
    vecs.push_back(mk("round_carry",  1'b0, EXP_BIAS,       48'h7FFFFFC00000, 1'b0, 1'b0, 1'b0, 32'h40000000, 3'b001));
    vecs.push_back(mk("overflow",     1'b0, 2*EXP_BIAS,     48'h800000000000, 1'b0, 1'b0, 1'b0, 32'h7F800000, 3'b101));
    vecs.push_back(mk("underflow",    1'b1, -5,             48'h800000000000, 1'b0, 1'b0, 1'b0, 32'h80000000, 3'b011));
    vecs.push_back(mk("nan_over_inf", 1'b1, EXP_BIAS,       48'h000000000000, 1'b1, 1'b1, 1'b0, 32'h7FC00000, 3'b000));
    vecs.push_back(mk("inf_over_zero",1'b1, EXP_BIAS,       48'h000000000000, 1'b0, 1'b1, 1'b1, 32'hFF800000, 3'b000));
    vecs.push_back(mk("zero_flag",    1'b1, EXP_BIAS,       48'h900000000000, 1'b0, 1'b0, 1'b1, 32'h80000000, 3'b000));
    vecs.push_back(mk("min_normal",   1'b0, 0,              48'h800000000000, 1'b0, 1'b0, 1'b0, 32'h00800000, 3'b000));
    vecs.push_back(mk("exp_zero_uf",  1'b0, 0,              48'h400000000000, 1'b0, 1'b0, 1'b0, 32'h00000000, 3'b011));
    vecs.push_back(mk("max_normal",   1'b0, 2*EXP_BIAS,     48'h400000000000, 1'b0, 1'b0, 1'b0, 32'h7F000000, 3'b000));
    vecs.push_back(mk("carry_ovf",    1'b0, 2*EXP_BIAS,     48'h7FFFFFC00000, 1'b0, 1'b0, 1'b0, 32'h7F800000, 3'b101));
    vecs.push_back(mk("sticky_only",  1'b0, EXP_BIAS,       48'h400000200001, 1'b0, 1'b0, 1'b0, 32'h3F800000, 3'b001));
    vecs.push_back(mk("guard_sticky", 1'b0, EXP_BIAS,       48'h400000600000, 1'b0, 1'b0, 1'b0, 32'h3F800001, 3'b001));
    vecs.push_back(mk("b47_tie",      1'b0, EXP_BIAS,       48'h800000800000, 1'b0, 1'b0, 1'b0, 32'h40000000, 3'b001));
    vecs.push_back(mk("carry_to_min", 1'b0, -1,             48'hFFFFFF800000, 1'b0, 1'b0, 1'b0, 32'h00800000, 3'b001));

    // Reset state
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    drive(1'b0, 0, 48'h0, 1'b0, 1'b0, 1'b0);
    tick(); tick();
    rst = 1'b0;
    chk("rst out_valid",  {31'h0, out_valid}, 32'h0);
    chk("rst out_result", out_result, 32'h0);
    chk("rst flags", {29'h0, out_overflow, out_underflow, out_inexact}, 32'h0);
    chk("rst in_ready", {31'h0, in_ready}, 32'h1);

    // Directed vectors, one beat at a time
    foreach (vecs[i]) begin
      drive(vecs[i].sign, vecs[i].exp, vecs[i].product, vecs[i].nan, vecs[i].inf, vecs[i].zero);
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      chk({vecs[i].name, " latency"}, {31'h0, out_valid}, 32'h0);
      tick();
      chk({vecs[i].name, " valid"}, {31'h0, out_valid}, 32'h1);
      chk({vecs[i].name, " result"}, out_result, vecs[i].res);
      chk({vecs[i].name, " flags"}, {29'h0, out_overflow, out_underflow, out_inexact},
          {29'h0, vecs[i].flags});
    end

    // Bubble: the last result stays put while valid drops
    tick();
    chk("bubble valid", {31'h0, out_valid}, 32'h0);
    chk("bubble hold", out_result, vecs[vecs.size()-1].res);

    // Backpressure: 4 beats, out_ready low in cycles 3..5
    bp_exp[0] = 32'h40100000; bp_exp[1] = 32'h40900000;
    bp_exp[2] = 32'h41100000; bp_exp[3] = 32'h41900000;
    sent = 0; rcvd = 0; saw_stall = 1'b0; prev_stall = 1'b0; prev_res = 32'h0; extra = 0;
    for (int c = 0; c < 40 && rcvd < 4; c++) begin
      out_ready = !(c >= 3 && c <= 5);
      if (sent < 4) begin
        drive(1'b0, EXP_BIAS + sent, 48'h900000000000, 1'b0, 1'b0, 1'b0);
        in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      #1;
      if (prev_stall) chk("bp hold", out_result, prev_res);
      prev_stall = out_valid && !out_ready;
      prev_res   = out_result;
      if (!in_ready) saw_stall = 1'b1;
      if (out_valid && out_ready) begin
        chk("bp order", out_result, bp_exp[rcvd]);
        rcvd++;
      end
      if (in_valid && in_ready) sent++;
      tick();
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    chk("bp received", rcvd, 4);
    chk("bp in_ready dropped", {31'h0, saw_stall}, 32'h1);
    for (int c = 0; c < 4; c++) begin
      if (out_valid) extra++;
      tick();
    end
    chk("bp no duplicate", extra, 0);

    // Reset with two beats in flight
    out_ready = 1'b0;
    drive(1'b1, EXP_BIAS, 48'h900000000000, 1'b0, 1'b0, 1'b0);
    in_valid = 1'b1;
    tick();
    drive(1'b0, EXP_BIAS + 1, 48'h900000000000, 1'b0, 1'b0, 1'b0);
    tick();
    in_valid = 1'b0;
    chk("mid beat A at output", out_result, 32'hC0100000);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid rst out_valid", {31'h0, out_valid}, 32'h0);
    chk("mid rst out_result", out_result, 32'h0);
    chk("mid rst in_ready", {31'h0, in_ready}, 32'h1);
    out_ready = 1'b1;
    extra = 0;
    for (int c = 0; c < 5; c++) begin
      if (out_valid) extra++;
      tick();
    end
    chk("mid rst discarded", extra, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
